// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default framing parameters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int DEFAULT_CLK_DIV = 10417;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value selects the idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability-resolving flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a down-counter, byte delivered on a valid/ready port
// with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);

    rx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  busy_q, busy_d;
    logic                  rx_s;
    logic                  expired_s;
    logic                  deliver_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    assign expired_s = (cnt_q == {CW{1'b0}});

    // Next-state logic: frame FSM, bit timer, shift register and output handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        deliver_s = 1'b0;

        if ((state_q == START || state_q == DATA || state_q == STOP) && !expired_s) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (expired_s && rx_s) begin
                    state_d = IDLE;
                end else if (expired_s) begin
                    state_d = DATA;
                    cnt_d   = FULL_LOAD;
                    bit_d   = {IW{1'b0}};
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (expired_s) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + IDX_ONE;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (expired_s && rx_s) begin
                    deliver_s = 1'b1;
                    state_d   = IDLE;
                end else if (expired_s) begin
                    ferr_d  = 1'b1;
                    state_d = BREAK;
                end else begin
                    state_d = STOP;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The receive path never waits: an unaccepted byte makes the new one overrun.
        if (deliver_s && (!valid_q || rx_ready)) begin
            data_d  = shift_d;
            valid_d = 1'b1;
        end else if (deliver_s) begin
            ovr_d = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            bit_q   <= {IW{1'b0}};
            shift_q <= {DATA_BITS{1'b0}};
            data_q  <= {DATA_BITS{1'b0}};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;

endmodule
